// File: rtl/pattern_matcher.sv
// Multi-channel streaming pattern matcher.
// Each channel compares the last len accepted characters against its own pattern RAM.
module pattern_matcher #(
    parameter int CW   = 8,
    parameter int PLEN = 8,
    parameter int NPAT = 2,
    parameter int CNTW = 16,
    localparam int PW  = (NPAT > 1) ? $clog2(NPAT) : 1,
    localparam int PI  = (PLEN > 1) ? $clog2(PLEN) : 1,
    localparam int LW  = $clog2(PLEN + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_we,
    input  logic [PW-1:0]        cfg_pat,
    input  logic [PI-1:0]        cfg_pos,
    input  logic [CW-1:0]        cfg_char,
    input  logic                 cfg_len_we,
    input  logic [LW-1:0]        cfg_len,
    input  logic [NPAT-1:0]      cfg_nolap,
    input  logic                 in_valid,
    input  logic [CW-1:0]        in_char,
    input  logic                 clr_cnt,
    output logic [NPAT-1:0]      match_vec,
    output logic [NPAT*CNTW-1:0] match_cnt
);

    logic [CW-1:0]   hist   [NPAT][PLEN];
    logic [CW-1:0]   pat    [NPAT][PLEN];
    logic [LW-1:0]   fill   [NPAT];
    logic [LW-1:0]   len    [NPAT];
    logic [LW-1:0]   fill_n [NPAT];
    logic [CNTW-1:0] cnt    [NPAT];
    logic [NPAT-1:0] hit;
    logic [NPAT-1:0] match_q;
    logic [LW-1:0]   len_wr;

    assign len_wr = (int'(cfg_len) > PLEN) ? LW'(PLEN) : cfg_len;

    // History slot j (0 = newest) must equal pattern position len-1-j.
    always_comb begin : match_logic
        logic          eq;
        logic [CW-1:0] newh [PLEN];
        hit = '0;
        for (int k = 0; k < NPAT; k++) begin
            fill_n[k] = (fill[k] == LW'(PLEN)) ? fill[k] : fill[k] + LW'(1);
            newh[0] = in_char;
            for (int j = 1; j < PLEN; j++) begin
                newh[j] = hist[k][j-1];
            end
            eq = 1'b1;
            for (int j = 0; j < PLEN; j++) begin
                for (int p = 0; p < PLEN; p++) begin
                    if (j < int'(len[k]) && p + j == int'(len[k]) - 1 &&
                        newh[j] != pat[k][p]) begin
                        eq = 1'b0;
                    end
                end
            end
            hit[k] = in_valid && (len[k] != '0) &&
                     (fill_n[k] >= len[k]) && eq;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_q <= '0;
            for (int k = 0; k < NPAT; k++) begin
                fill[k] <= '0;
                len[k]  <= '0;
                cnt[k]  <= '0;
                for (int j = 0; j < PLEN; j++) begin
                    hist[k][j] <= '0;
                    pat[k][j]  <= '0;
                end
            end
        end else begin
            match_q <= hit;
            for (int k = 0; k < NPAT; k++) begin
                if (in_valid) begin
                    hist[k][0] <= in_char;
                    for (int j = 1; j < PLEN; j++) begin
                        hist[k][j] <= hist[k][j-1];
                    end
                    fill[k] <= (hit[k] && cfg_nolap[k]) ? '0 : fill_n[k];
                end
                if (clr_cnt) begin
                    cnt[k] <= hit[k] ? CNTW'(1) : '0;
                end else if (hit[k] && cnt[k] != '1) begin
                    cnt[k] <= cnt[k] + CNTW'(1);
                end
                // A length write restarts the channel; it wins over the shift.
                if (cfg_len_we && int'(cfg_pat) == k) begin
                    fill[k] <= '0;
                    len[k]  <= len_wr;
                end
                if (cfg_we && int'(cfg_pat) == k && int'(cfg_pos) < PLEN) begin
                    pat[k][cfg_pos] <= cfg_char;
                end
            end
        end
    end

    assign match_vec = match_q;

    always_comb begin
        for (int k = 0; k < NPAT; k++) begin
            match_cnt[k*CNTW +: CNTW] = cnt[k];
        end
    end

endmodule

// File: tb/tb_pattern_matcher.sv
// Testbench for pattern_matcher: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_pattern_matcher;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [0:0]  cfg_pat = '0;
    logic [2:0]  cfg_pos = '0;
    logic [7:0]  cfg_char = '0;
    logic        cfg_len_we = 1'b0;
    logic [3:0]  cfg_len = '0;
    logic [1:0]  cfg_nolap = '0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_char = '0;
    logic        clr_cnt = 1'b0;
    logic [1:0]  match_vec;
    logic [31:0] match_cnt;
    logic [1:0]  mv2;
    logic [3:0]  mcnt2;

    pattern_matcher #(.CW(8), .PLEN(8), .NPAT(2), .CNTW(16)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pat(cfg_pat),
        .cfg_pos(cfg_pos), .cfg_char(cfg_char), .cfg_len_we(cfg_len_we),
        .cfg_len(cfg_len), .cfg_nolap(cfg_nolap), .in_valid(in_valid),
        .in_char(in_char), .clr_cnt(clr_cnt), .match_vec(match_vec),
        .match_cnt(match_cnt)
    );

    pattern_matcher #(.CW(8), .PLEN(8), .NPAT(2), .CNTW(2)) dut2 (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pat(cfg_pat),
        .cfg_pos(cfg_pos), .cfg_char(cfg_char), .cfg_len_we(cfg_len_we),
        .cfg_len(cfg_len), .cfg_nolap(cfg_nolap), .in_valid(in_valid),
        .in_char(in_char), .clr_cnt(clr_cnt), .match_vec(mv2),
        .match_cnt(mcnt2)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // reference model: chars accepted since the last fill reset (max 8)
    logic [7:0] mq [2][$];
    logic [7:0] nq [2][$];
    logic [7:0] mpat [2][8];
    int         mlen [2];
    int         mc1 [2];
    int         mc2 [2];
    int         sidx;
    logic [31:0] pm0, pm1;

    const string STREAM = "AABABA__JUSTMONIKA__CDEDE";

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            mq[k].delete();
            mlen[k] = 0;
            mc1[k] = 0;
            mc2[k] = 0;
            for (int p = 0; p < 8; p++) mpat[k][p] = '0;
        end
    endtask

    task automatic tick();
        logic [1:0]  em;
        logic [1:0]  nl;
        logic [7:0]  t [$];
        int          L;
        em = '0;
        nl = cfg_nolap;
        for (int k = 0; k < 2; k++) begin
            t = mq[k];
            if (in_valid) begin
                t.push_back(in_char);
                if (t.size() > 8) void'(t.pop_front());
            end
            L = mlen[k];
            if (in_valid && L != 0 && t.size() >= L) begin
                em[k] = 1'b1;
                for (int p = 0; p < L; p++)
                    if (t[t.size() - L + p] != mpat[k][p]) em[k] = 1'b0;
            end
            nq[k] = t;
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            mq[k] = nq[k];
            if (em[k] && nl[k]) mq[k].delete();
            if (clr_cnt) begin
                mc1[k] = em[k] ? 1 : 0;
                mc2[k] = em[k] ? 1 : 0;
            end else if (em[k]) begin
                if (mc1[k] < 65535) mc1[k]++;
                if (mc2[k] < 3) mc2[k]++;
            end
        end
        if (cfg_len_we) begin
            mlen[cfg_pat] = (cfg_len > 8) ? 8 : int'(cfg_len);
            mq[cfg_pat].delete();
        end
        if (cfg_we) mpat[cfg_pat][cfg_pos] = cfg_char;
        check("match_vec", match_vec, em);
        check("match_cnt", match_cnt, {16'(mc1[1]), 16'(mc1[0])});
        check("mv_cntw2", mv2, em);
        check("cnt_cntw2", mcnt2, {2'(mc2[1]), 2'(mc2[0])});
        if (!in_valid) check("idle_mv", match_vec, 2'b00);
        if (match_vec[0]) pm0 |= 32'(1) << sidx;
        if (match_vec[1]) pm1 |= 32'(1) << sidx;
        cfg_we = 1'b0;
        cfg_len_we = 1'b0;
        clr_cnt = 1'b0;
        in_valid = 1'b0;
        sidx = 31;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_async_mv", {mv2, match_vec}, 4'h0);
        check("rst_async_cnt", {mcnt2, match_cnt}, 36'h0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_mv", {mv2, match_vec}, 4'h0);
        check("rst_hold_cnt", {mcnt2, match_cnt}, 36'h0);
        rst = 1'b0;
        model_clear();
        pm0 = '0;
        pm1 = '0;
        sidx = 31;
    endtask

    task automatic set_pat(int k, string s, bit wl);
        for (int i = 0; i < s.len(); i++) begin
            cfg_we = 1'b1;
            cfg_pat = 1'(k);
            cfg_pos = 3'(i);
            cfg_char = s[i];
            tick();
        end
        if (wl) begin
            cfg_len_we = 1'b1;
            cfg_pat = 1'(k);
            cfg_len = 4'(s.len());
            tick();
        end
    endtask

    task automatic feed(string s, int base);
        for (int i = 0; i < s.len(); i++) begin
            in_valid = 1'b1;
            in_char = s[i];
            sidx = base + i;
            tick();
        end
    endtask

    initial begin
        model_clear();
        pm0 = '0;
        pm1 = '0;
        sidx = 31;
        #1;
        check("reset_state", {mv2, match_vec, mcnt2, match_cnt}, 38'h0);
        do_reset();

        // overlapping ABA and MONIKA
        cfg_nolap = 2'b00;
        set_pat(0, "ABA", 1);
        set_pat(1, "MONIKA", 1);
        pm0 = '0;
        pm1 = '0;
        feed(STREAM, 0);
        check("ovl_ch0_pulses", pm0, 32'h28);
        check("ovl_ch1_pulses", pm1, 32'h20000);
        check("ovl_cnt0", match_cnt[15:0], 16'd2);
        check("ovl_cnt1", match_cnt[31:16], 16'd1);

        // non-overlapping ABA
        do_reset();
        cfg_nolap = 2'b01;
        set_pat(0, "ABA", 1);
        set_pat(1, "MONIKA", 1);
        pm0 = '0;
        feed(STREAM, 0);
        check("nolap_ch0_pulses", pm0, 32'h8);
        check("nolap_cnt0", match_cnt[15:0], 16'd1);

        // EDE with idle gap before the final E
        do_reset();
        cfg_nolap = 2'b00;
        set_pat(0, "EDE", 1);
        pm0 = '0;
        feed(STREAM.substr(0, 23), 0);
        repeat (3) tick();
        feed("E", 24);
        check("gap_ch0_pulses", pm0, 32'h1000000);
        check("gap_cnt0", match_cnt[15:0], 16'd1);

        // saturation on the 2-bit counter, clear coincident with a match
        do_reset();
        set_pat(0, "A", 1);
        feed("AAAAA", 0);
        check("sat_cnt2", mcnt2[1:0], 2'd3);
        check("sat_cnt16", match_cnt[15:0], 16'd5);
        clr_cnt = 1'b1;
        feed("A", 5);
        check("clr_hit_cnt2", mcnt2[1:0], 2'd1);
        check("clr_hit_cnt16", match_cnt[15:0], 16'd1);

        // reset mid-stream discards the partial MONIKA
        do_reset();
        set_pat(1, "MONIKA", 1);
        feed(STREAM.substr(0, 15), 0);
        do_reset();
        set_pat(1, "MONIKA", 1);
        pm1 = '0;
        feed("KA", 16);
        check("rst_mid_pulses", pm1, 32'h0);
        check("rst_mid_cnt1", match_cnt[31:16], 16'd0);

        // length write coincident with the final A
        do_reset();
        set_pat(1, "MONIKA", 0);
        pm1 = '0;
        feed("MONIK", 0);
        cfg_len_we = 1'b1;
        cfg_pat = 1'b1;
        cfg_len = 4'd6;
        feed("A", 5);
        check("lenwr_nomatch", match_vec[1], 1'b0);
        feed("MONIKA", 6);
        check("lenwr_pulses", pm1, 32'h800);
        check("lenwr_cnt1", match_cnt[31:16], 16'd1);

        // random traffic against the model
        do_reset();
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < 3; p++) begin
                cfg_we = 1'b1;
                cfg_pat = 1'(k);
                cfg_pos = 3'(p);
                cfg_char = 8'h41 + 8'($urandom_range(0, 1));
                tick();
            end
            cfg_len_we = 1'b1;
            cfg_pat = 1'(k);
            cfg_len = 4'($urandom_range(1, 3));
            tick();
        end
        for (int c = 0; c < 2000; c++) begin
            in_valid = ($urandom_range(0, 9) < 8);
            in_char = 8'h41 + 8'($urandom_range(0, 2));
            sidx = 31;
            if ($urandom_range(0, 19) == 0) cfg_nolap = 2'($urandom);
            clr_cnt = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 29) == 0) begin
                cfg_we = 1'b1;
                cfg_pat = 1'($urandom);
                cfg_pos = 3'($urandom_range(0, 3));
                cfg_char = 8'h41 + 8'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 49) == 0) begin
                cfg_len_we = 1'b1;
                cfg_pat = 1'($urandom);
                cfg_len = ($urandom_range(0, 3) == 0) ?
                          4'($urandom_range(9, 15)) : 4'($urandom_range(0, 4));
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pattern_matcher.md
PATTERN_MATCHER -- requirements
Module: pattern_matcher

Interface
REQ-001 Parameter: CW, default 8, character width in bits.
REQ-002 Parameter: PLEN, default 8, maximum pattern length in characters (>=1).
REQ-003 Parameter: NPAT, default 2, number of independent pattern channels (>=1).
REQ-004 Parameter: CNTW, default 16, match-counter width per channel.
REQ-005 One clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  clock; all state updates on posedge.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 cfg_we  in  1  write one pattern character.
REQ-009 cfg_pat  in  max(1,$clog2(NPAT))  target channel for cfg_we/cfg_len_we.
REQ-010 cfg_pos  in  max(1,$clog2(PLEN))  character position; 0 is the first character of the pattern.
REQ-011 cfg_char  in  CW  character value.
REQ-012 cfg_len_we  in  1  write pattern length.
REQ-013 cfg_len  in  $clog2(PLEN+1)  pattern length; 0 disables the channel.
REQ-014 cfg_nolap  in  NPAT  per channel: 1 = non-overlapping mode, 0 = overlapping.
REQ-015 in_valid  in  1  in_char valid this cycle; no backpressure.
REQ-016 in_char  in  CW  stream character.
REQ-017 clr_cnt  in  1  synchronous clear of all match counters.
REQ-018 match_vec  out  NPAT  per-channel one-cycle match pulse.
REQ-019 match_cnt  out  NPAT*CNTW  per-channel saturating match counts; channel k at bits [k*CNTW +: CNTW].

Function
REQ-020 Each channel keeps a PLEN-deep character history, a fill count 0..PLEN (saturating), a pattern RAM of PLEN x CW, a length register and a counter.
REQ-021 On in_valid, every channel shifts in_char into its history and increments fill (saturating at PLEN).
REQ-022 Channel k matches on an accepted character when len!=0, fill (after increment) >= len, and the last len accepted characters equal pattern positions 0..len-1 in order.
REQ-023 match_vec[k] is registered: high for exactly the cycle after the edge accepting the final matching character, low otherwise.
REQ-024 On a match, match_cnt[k] increments by 1 on the same edge that sets match_vec[k] and saturates at 2^CNTW-1.
REQ-025 Overlapping mode: history and fill are unaffected by a match; e.g. pattern "ABA" matches twice in "ABABA".
REQ-026 Non-overlapping mode: on a match, fill[k] resets to 0, so the next match needs len fresh characters.
REQ-027 When in_valid is low, history, fill and match_vec do not change; match_vec is 0.
REQ-028 cfg_we/cfg_len_we take effect at the edge. A character accepted in the same cycle is compared against the old configuration.
REQ-029 cfg_len_we clears fill of the target channel. cfg_we does not clear fill.
REQ-030 cfg_len > PLEN is clamped to PLEN. cfg_pat >= NPAT and cfg_pos >= PLEN writes are ignored.
REQ-031 clr_cnt zeroes all counters. If clr_cnt and a match occur on the same edge, the counter becomes 1.
REQ-032 cfg_nolap is sampled each cycle; changing it mid-stream affects only subsequent matches.

Reset
REQ-033 While rst is high, all outputs and all internal state are forced to 0 asynchronously:
- match_vec = 0, match_cnt = 0
- fill = 0, history = 0
- lengths = 0 (all channels disabled), pattern RAM = 0
REQ-034 Reset asserted mid-stream discards partial matches; after release, matching restarts with fill = 0 and configuration must be rewritten.

Verification
REQ-035 Test stream: "AABABA__JUSTMONIKA__CDEDE", one char per cycle, indices 0..24. Setup: ch0 = "ABA" (overlapping), ch1 = "MONIKA". Expected:
- match_vec[0] pulses after indices 3 and 5; cnt0 = 2.
- match_vec[1] pulses after index 17; cnt1 = 1.
REQ-036 Same stream with ch0 in non-overlapping mode -> a single match after index 3; cnt0 = 1.
REQ-037 ch0 = "EDE", with in_valid low for 3 cycles between 'D' (index 23) and 'E' (index 24):
- match still occurs after index 24;
- no pulses occur during the idle cycles.
REQ-038 CNTW = 2, pattern "A", 5 consecutive 'A' -> cnt saturates at 3. Then clr_cnt coincident with another 'A' -> cnt = 1.
REQ-039 Assert rst after index 15 of the MONIKA stream, release, rewrite the configuration, then feed "KA" -> no match; outputs are 0 during reset.
REQ-040 cfg_len_we (len = 6) in the same cycle the final 'A' of "MONIKA" is accepted, with the old len = 0 -> no match that cycle and fill cleared. Then "MONIKA" is fed again -> one match.
